// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator store/load paths.
package cnn_accel_pkg;

  localparam int unsigned DefaultAw = 16;
  localparam int unsigned DefaultDw = 32;

  // Store-drain sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StFlush,
    StDone
  } st_state_e;

  // Words held by one out_fm bank: its channel slice times the full row/column tile.
  function automatic int unsigned bank_capacity(input int unsigned tn, input int unsigned y,
                                                input int unsigned tr, input int unsigned tc);
    return (tn / y) * tr * tc;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: the head entry is visible on rd_data whenever
// empty is low. Push and pop may coincide, including when full or empty.
module sync_fifo_fwft #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees the head slot this cycle, so a push into a full FIFO is accepted alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // A push that cannot be stored is a caller bug.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/out_fm_st_drain.sv
// Store-side drain of one out_fm bank: reads the bank once through its sequential port and
// streams every word, tagged with its external address, over a valid/ready interface.
module out_fm_st_drain
  import cnn_accel_pkg::*;
#(
  parameter int unsigned AW         = DefaultAw,
  parameter int unsigned DW         = DefaultDw,
  parameter int unsigned Tn         = 16,
  parameter int unsigned Tr         = 64,
  parameter int unsigned Tc         = 16,
  parameter int unsigned Y          = 4,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_start,
  input  logic [AW-1:0] base_addr,
  output logic          rd_ena,
  input  logic [DW-1:0] rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_addr,
  output logic          busy,
  output logic          st_done
);

  localparam logic [AW:0]  Cap    = (AW + 1)'(bank_capacity(Tn, Y, Tr, Tc));
  localparam logic [AW:0]  CapM1  = Cap - (AW + 1)'(1);
  localparam logic [AW:0]  CntOne = (AW + 1)'(1);
  localparam int unsigned  IW     = $clog2(RD_LAT + 1);
  localparam int unsigned  CW     = $clog2(FIFO_DEPTH + 1);

  st_state_e     state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   issue_cnt_q, issue_cnt_d;
  logic [AW:0]   out_cnt_q, out_cnt_d;
  logic [RD_LAT-1:0] lat_q, lat_d;
  logic [IW-1:0] inflight;
  logic          credit_ok;
  logic          start_acc;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign start_acc = (state_q == StIdle) && st_start;
  assign push      = lat_q[RD_LAT-1];
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign m_addr    = base_q + out_cnt_q[AW-1:0];

  // Count strobes still travelling through the bank pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) inflight = inflight + IW'(lat_q[i]);
  end

  // Only strobe when every word already requested is guaranteed a FIFO slot.
  always_comb begin
    credit_ok = (32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (st_start) state_d = StIssue;
      StIssue: if (rd_ena && (issue_cnt_q == CapM1)) state_d = StFlush;
      // Use the post-handshake count so st_done follows the last handshake by one cycle.
      StFlush: if ((inflight == '0) && (out_cnt_d == Cap)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rd_ena  = (state_q == StIssue) && credit_ok && (issue_cnt_q < Cap);
    busy    = (state_q != StIdle);
    st_done = (state_q == StDone);
  end

  // Datapath next-state: latch base and clear counters on an accepted start, else advance.
  always_comb begin
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    lat_d       = lat_q << 1;
    lat_d[0]    = rd_ena;
    if (start_acc) begin
      base_d      = base_addr;
      issue_cnt_d = '0;
      out_cnt_d   = '0;
    end else begin
      if (rd_ena) issue_cnt_d = issue_cnt_q + CntOne;
      if (pop)    out_cnt_d   = out_cnt_q + CntOne;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      lat_q       <= '0;
    end else begin
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      lat_q       <= lat_d;
    end
  end

  sync_fifo_fwft #(
    .DW   (DW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_data(rd_data),
    .pop    (pop),
    .rd_data(m_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // The credit check must make overflow impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_out_fm_st_drain.sv
module tb_out_fm_st_drain;

  localparam int Cap   = 16;
  localparam int Lat   = 2;
  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        rd_ena;
  logic [31:0] rd_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [15:0] m_addr;
  logic        busy;
  logic        st_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  out_fm_st_drain #(
    .AW(16), .DW(32), .Tn(4), .Tr(4), .Tc(4), .Y(4), .RD_LAT(Lat), .FIFO_DEPTH(Depth)
  ) dut (
    .clk(clk), .rst(rst), .st_start(st_start), .base_addr(base_addr), .rd_ena(rd_ena),
    .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_addr(m_addr), .busy(busy), .st_done(st_done)
  );

  // Bank model: sequential read port, registered address stage plus registered output.
  logic [31:0] mem [Cap];
  logic [3:0]  bank_cnt;
  logic [31:0] bank_s1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_cnt <= '0;
      bank_s1  <= '0;
      rd_data  <= '0;
    end else begin
      if (rd_ena) begin
        bank_s1  <= mem[bank_cnt];
        bank_cnt <= bank_cnt + 4'd1;
      end
      rd_data <= bank_s1;
    end
  end

  // Per-store observations.
  logic [31:0] got_d [$];
  logic [15:0] got_a [$];
  int strobes, strobes_early, first_v, first_hs, last_hs, done_cyc, done_pulses;
  int stab_viol, busy_bad, busy_after;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      2:       return (c >= 20);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One store: st_start in cycle 0, optional extra st_start at restart_at, optional early abort.
  task automatic run_store(input logic [15:0] base, input int mode, input int restart_at,
                           input int abort_words);
    logic        prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic [15:0] pa = '0;
    got_d.delete();
    got_a.delete();
    strobes = 0; strobes_early = 0; first_v = -1; first_hs = -1; last_hs = -1;
    done_cyc = -1; done_pulses = 0; stab_viol = 0; busy_bad = 0; busy_after = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      st_start  = (c == 0) || (c == restart_at);
      base_addr = (c == 0) ? base : (base ^ 16'h5a5a);
      m_ready   = ready_for(mode, c);
      @(negedge clk);
      if (rd_ena) begin
        strobes++;
        if (c < 20) strobes_early++;
      end
      if (m_valid && first_v < 0) first_v = c;
      if (prev_stall && (!m_valid || m_data !== pd || m_addr !== pa)) stab_viol++;
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pa = m_addr;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_a.push_back(m_addr);
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      if (c == 0) begin
        if (busy) busy_bad++;
      end else if (done_cyc < 0 && !busy) begin
        busy_bad++;
      end
      if (done_cyc >= 0 && (busy || rd_ena || st_done)) busy_after++;
      if (st_done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (abort_words > 0 && got_d.size() == abort_words) break;
      if (done_cyc >= 0 && c == done_cyc + 2) break;
    end
    st_start = 1'b0;
  endtask

  // Reference: word i of a store is bank entry i at base + i (mod 2^16).
  task automatic verify_store(input string tag, input logic [15:0] base);
    check({tag, "_count"}, 64'(got_d.size()), 64'(Cap));
    for (int i = 0; i < Cap && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(mem[i]));
      check($sformatf("%s_addr%0d", tag, i), 64'(got_a[i]), 64'(16'(base + 16'(i))));
    end
  endtask

  task automatic verify_ctrl(input string tag);
    check({tag, "_strobes"}, 64'(strobes), 64'(Cap));
    check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'(1));
    check({tag, "_done_lat"}, 64'(done_cyc), 64'(last_hs + 1));
    check({tag, "_done_pulses"}, 64'(done_pulses), 64'(1));
    check({tag, "_stable"}, 64'(stab_viol), 64'(0));
    check({tag, "_busy"}, 64'(busy_bad), 64'(0));
    check({tag, "_idle_after"}, 64'(busy_after), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_ena"}, 64'(rd_ena), 64'(0));
    check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    check({tag, "_m_data"}, 64'(m_data), 64'(0));
    check({tag, "_m_addr"}, 64'(m_addr), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_st_done"}, 64'(st_done), 64'(0));
  endtask

  initial begin
    logic [15:0] b;
    for (int i = 0; i < Cap; i++) mem[i] = 32'(i);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Sanity: full throughput, one word per cycle.
    run_store(16'h0100, 0, -1, 0);
    verify_store("sanity", 16'h0100);
    verify_ctrl("sanity");
    // m_valid appears RD_LAT+1 edges after the edge accepting st_start (cycle index Lat+2).
    check("sanity_first_valid", 64'(first_v), 64'(Lat + 2));
    check("sanity_streaming", 64'(last_hs - first_hs), 64'(Cap - 1));

    // Backpressure with 1,0,0,1 ready pattern and random bank contents.
    for (int i = 0; i < Cap; i++) mem[i] = $urandom;
    b = 16'($urandom);
    run_store(b, 1, -1, 0);
    verify_store("bp", b);
    verify_ctrl("bp");

    // Stalled from start: strobes limited by FIFO credit.
    for (int i = 0; i < Cap; i++) mem[i] = $urandom;
    b = 16'($urandom);
    run_store(b, 2, -1, 0);
    check("stall_strobes_early", 64'(strobes_early), 64'(Depth));
    verify_store("stall", b);
    verify_ctrl("stall");

    // Address wrap with random backpressure.
    for (int i = 0; i < Cap; i++) mem[i] = $urandom;
    run_store(16'hFFFE, 3, -1, 0);
    verify_store("wrap", 16'hFFFE);
    verify_ctrl("wrap");

    // Second st_start during ISSUE is ignored.
    for (int i = 0; i < Cap; i++) mem[i] = 32'(i);
    run_store(16'h2000, 0, 3, 0);
    verify_store("restart", 16'h2000);
    verify_ctrl("restart");

    // st_start in the DONE cycle (cycle 20 at full throughput) is ignored.
    run_store(16'h3000, 0, 20, 0);
    verify_store("start_at_done", 16'h3000);
    verify_ctrl("start_at_done");

    // Back-to-back store: bank counter realigned, first word is entry 0.
    run_store(16'h4000, 3, -1, 0);
    verify_store("b2b", 16'h4000);
    check("b2b_first_word", 64'(got_d.size() > 0 ? got_d[0] : 32'hdead_beef), 64'(0));

    // Reset in the middle of a store, then a clean store.
    for (int i = 0; i < Cap; i++) mem[i] = $urandom;
    run_store(16'h5000, 0, -1, 7);
    check("abort_words", 64'(got_d.size()), 64'(7));
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    b = 16'($urandom);
    run_store(b, 3, -1, 0);
    verify_store("after_reset", b);
    verify_ctrl("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
